seven_segment_scroll_driver: RTL and testbench

Parametrised multiplexed seven-segment display driver for the board top level. It holds a message buffer of raw segment patterns and time-multiplexes them across DIGITS common-anode digits, with per-slot anti-ghosting blanking. An optional scroll mode rotates the message across the display at a programmable rate. It replaces hard-wired letter/digit assignments with a loadable, scanned, scrollable display.

---
 rtl/seven_segment_scroll_driver.sv | 88 ++++++++
 tb/tb_seven_segment_scroll_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_scroll_driver.sv
// Scanned, optionally scrolling seven-segment driver over a loadable message buffer.
// Latency: outputs register one cycle after scan/scroll state and buffer contents; no backpressure, writes always accepted.
module seven_segment_scroll_driver #(
  parameter int DIGITS     = 4,
  parameter int MSG_LEN    = 8,
  parameter int SCAN_DIV   = 1024,
  parameter int BLANK      = 64,
  parameter int SCROLL_DIV = 12000000,
  localparam int AW = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [7:0]        wr_data,
  input  logic              display_en,
  input  logic              scroll_en,
  output logic [7:0]        abcdefgh,
  output logic [DIGITS-1:0] digit
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

  logic [7:0]    msg_buf [MSG_LEN];
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [SW-1:0] scnt;
  logic [AW-1:0] offset;
  logic [AW-1:0] offset_nxt;
  logic [AW-1:0] sel;
  logic          in_blank;

  // Explicit wrap keeps offset legal even when MSG_LEN does not fill AW bits.
  assign offset_nxt = (offset == AW'(MSG_LEN - 1)) ? '0 : offset + AW'(1);
  assign sel        = offset + AW'(idx);
  assign in_blank   = (cnt < CW'(BLANK));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        msg_buf[i] <= 8'hFF;
      end
    end else if (wr_en) begin
      msg_buf[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CW'(SCAN_DIV - 1)) begin
      cnt <= '0;
      idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + IW'(1);
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Disabling scroll pins the display to entry 0 so re-enabling restarts cleanly.
  always_ff @(posedge clk) begin
    if (reset || !scroll_en) begin
      scnt   <= '0;
      offset <= '0;
    end else if (scnt == SW'(SCROLL_DIV - 1)) begin
      scnt   <= '0;
      offset <= offset_nxt;
    end else begin
      scnt   <= scnt + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      abcdefgh <= 8'hFF;
      digit    <= '1;
    end else if (!display_en || in_blank) begin
      abcdefgh <= 8'hFF;
      digit    <= '1;
    end else begin
      abcdefgh <= msg_buf[sel];
      digit    <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: tb/tb_seven_segment_scroll_driver.sv
// Randomised and directed bench for seven_segment_scroll_driver against a cycle-count reference model.
module tb_seven_segment_scroll_driver;

  localparam int DIGITS     = 4;
  localparam int MSG_LEN    = 8;
  localparam int SCAN_DIV   = 8;
  localparam int BLANK      = 2;
  localparam int SCROLL_DIV = 64;

  logic       clk = 1'b0;
  logic       reset, wr_en, display_en, scroll_en;
  logic [2:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] abcdefgh;
  logic [3:0] digit;

  always #5 clk = ~clk;

  seven_segment_scroll_driver #(
    .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV),
    .BLANK(BLANK), .SCROLL_DIV(SCROLL_DIV)
  ) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .display_en(display_en), .scroll_en(scroll_en), .abcdefgh(abcdefgh), .digit(digit)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: n = edges since reset release, s = consecutive scroll-enabled edges.
  int         n, s;
  int         last_cnt, last_idx, last_off;
  logic [7:0] mbuf [MSG_LEN];
  logic [7:0] exp_seg;
  logic [3:0] exp_dig;

  task automatic tick();
    if (reset) begin
      n = 0;
      s = 0;
      for (int i = 0; i < MSG_LEN; i++) mbuf[i] = 8'hFF;
      exp_seg = 8'hFF;
      exp_dig = 4'hF;
    end else begin
      last_cnt = n % SCAN_DIV;
      last_idx = (n / SCAN_DIV) % DIGITS;
      last_off = (s / SCROLL_DIV) % MSG_LEN;
      if (!display_en || last_cnt < BLANK) begin
        exp_seg = 8'hFF;
        exp_dig = 4'hF;
      end else begin
        exp_seg = mbuf[(last_off + last_idx) % MSG_LEN];
        exp_dig = 4'hF ^ 4'(1 << last_idx);
      end
      if (wr_en) mbuf[wr_addr] = wr_data;
      n++;
      s = scroll_en ? s + 1 : 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    display_en = 1'b1; scroll_en = 1'b0;
    repeat (3) begin
      tick();
      vectors++;
      if (abcdefgh !== 8'hFF || digit !== 4'hF) begin
        miscompares++;
        $display("FAIL reset_state: got seg=%h dig=%b, want seg=ff dig=1111", abcdefgh, digit);
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (abcdefgh !== 8'hFF || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL blank_scan: got seg=%h dig=%b, want seg=ff dig=%b", abcdefgh, digit, exp_dig);
      end
    end
  endtask

  task automatic test_static_load();
    logic [7:0] chip [4];
    logic [7:0] want;
    int         lit [4];
    chip[0] = 8'h63; chip[1] = 8'hD1; chip[2] = 8'hF3; chip[3] = 8'h31;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = chip[i];
      tick();
      vectors++;
      if (abcdefgh !== exp_seg || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL load_write: got seg=%h dig=%b, want seg=%h dig=%b", abcdefgh, digit, exp_seg, exp_dig);
      end
    end
    wr_en = 1'b0;
    for (int i = 0; i < 4; i++) lit[i] = 0;
    for (int i = 0; i < 2 * DIGITS * SCAN_DIV; i++) begin
      tick();
      want = 8'hFF;
      case (digit)
        4'b1110: begin want = 8'h63; lit[0]++; end
        4'b1101: begin want = 8'hD1; lit[1]++; end
        4'b1011: begin want = 8'hF3; lit[2]++; end
        4'b0111: begin want = 8'h31; lit[3]++; end
        default: want = 8'hFF;
      endcase
      vectors++;
      if (abcdefgh !== want || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL static_scan: got seg=%h dig=%b, want seg=%h dig=%b", abcdefgh, digit, want, exp_dig);
      end
    end
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (lit[d] != 2 * (SCAN_DIV - BLANK)) begin
        miscompares++;
        $display("FAIL lit_cycles digit %0d: got %0d, want %0d", d, lit[d], 2 * (SCAN_DIV - BLANK));
      end
    end
  endtask

  task automatic test_scroll_wrap();
    int hits = 0;
    for (int i = 0; i < MSG_LEN; i++) begin
      wr_en = 1'b1; wr_addr = 3'(i); wr_data = 8'(i);
      tick();
    end
    wr_en = 1'b0;
    scroll_en = 1'b0;
    tick();
    scroll_en = 1'b1;
    for (int i = 0; i < (MSG_LEN + 1) * SCROLL_DIV; i++) begin
      tick();
      vectors++;
      if (abcdefgh !== exp_seg || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL scroll: got seg=%h dig=%b, want seg=%h dig=%b", abcdefgh, digit, exp_seg, exp_dig);
      end
      if (last_off == 6 && exp_dig == 4'b0111) begin
        hits++;
        vectors++;
        if (abcdefgh !== 8'h01) begin
          miscompares++;
          $display("FAIL scroll_wrap_char: got seg=%h, want seg=01", abcdefgh);
        end
      end
    end
    vectors++;
    if (hits == 0) begin
      miscompares++;
      $display("FAIL scroll_wrap_seen: got 0 offset-6 digit-3 cycles, want >0");
    end
    scroll_en = 1'b0;
    tick();
  endtask

  task automatic test_write_hazard();
    int guard = 0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h63;
    tick();
    wr_en = 1'b0;
    while (!(n % SCAN_DIV == 3 && (n / SCAN_DIV) % DIGITS == 0) && guard < 64) begin
      tick();
      guard++;
    end
    vectors++;
    if (guard >= 64) begin
      miscompares++;
      $display("FAIL hazard_align: got no aligned slot in 64 cycles, want one");
    end
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h61;
    tick();
    wr_en = 1'b0;
    vectors++;
    if (abcdefgh !== 8'h63 || digit !== 4'b1110) begin
      miscompares++;
      $display("FAIL hazard_old: got seg=%h dig=%b, want seg=63 dig=1110", abcdefgh, digit);
    end
    tick();
    vectors++;
    if (abcdefgh !== 8'h61 || digit !== 4'b1110) begin
      miscompares++;
      $display("FAIL hazard_new: got seg=%h dig=%b, want seg=61 dig=1110", abcdefgh, digit);
    end
  endtask

  task automatic test_toggles();
    display_en = 1'b0;
    repeat (10) begin
      tick();
      vectors++;
      if (abcdefgh !== 8'hFF || digit !== 4'hF) begin
        miscompares++;
        $display("FAIL display_off: got seg=%h dig=%b, want seg=ff dig=1111", abcdefgh, digit);
      end
    end
    display_en = 1'b1;
    scroll_en  = 1'b1;
    for (int i = 0; i < SCROLL_DIV + 20; i++) begin
      if (i == SCROLL_DIV + 6) scroll_en = 1'b0;
      tick();
      vectors++;
      if (abcdefgh !== exp_seg || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL toggle: got seg=%h dig=%b, want seg=%h dig=%b", abcdefgh, digit, exp_seg, exp_dig);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      wr_en      = ($urandom_range(0, 3) == 0);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 8'($urandom);
      display_en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) scroll_en = ~scroll_en;
      tick();
      vectors++;
      if (abcdefgh !== exp_seg || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL random: got seg=%h dig=%b, want seg=%h dig=%b", abcdefgh, digit, exp_seg, exp_dig);
      end
    end
    wr_en = 1'b0; display_en = 1'b1;
  endtask

  task automatic test_reset_mid();
    scroll_en = 1'b1;
    repeat (SCROLL_DIV + 12) tick();
    while (n % SCAN_DIV != 4) tick();
    reset = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h00;
    tick();
    vectors++;
    if (abcdefgh !== 8'hFF || digit !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_mid: got seg=%h dig=%b, want seg=ff dig=1111", abcdefgh, digit);
    end
    reset = 1'b0; wr_en = 1'b0; scroll_en = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      vectors++;
      if (abcdefgh !== 8'hFF || digit !== exp_dig) begin
        miscompares++;
        $display("FAIL post_reset_blank: got seg=%h dig=%b, want seg=ff dig=%b", abcdefgh, digit, exp_dig);
      end
    end
  endtask

  initial begin
    test_reset();
    test_static_load();
    test_scroll_wrap();
    test_write_hazard();
    test_toggles();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
